// File: rtl/cnnip_mem_pkg.sv
// Shared types and elaboration helpers for the banked CNN IP buffer memory.
package cnnip_mem_pkg;

    localparam int TAG_BK_W = 3;

    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int we_width(input int dw);
        return dw / 8;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [TAG_BK_W-1:0] bank;
    } rd_tag_t;

endpackage

// File: rtl/cnnip_mem_rr_arb.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past each winner.
module cnnip_mem_rr_arb
    import cnnip_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PTR_W = (NUM_PORTS > 1) ? clog2_safe(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;

    // Scan ports starting at the pointer; the first requester wins.
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = PTR_W'((idx + 1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (|req) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/cnnip_mem_banked.sv
// Multi-port, multi-bank byte-enable memory with per-bank round-robin arbitration
// and a fixed read latency per port.
module cnnip_mem_banked
    import cnnip_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_PORTS-1:0]                en,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     din,
    output logic [NUM_PORTS-1:0]                ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     dout,
    output logic [NUM_PORTS-1:0]                valid
);

    localparam int WE_W  = we_width(DATA_WIDTH);
    localparam int BK_W  = clog2_safe(NUM_BANKS);
    localparam int BKI_W = (BK_W > 0) ? BK_W : 1;
    localparam int ROW_W = ADDR_WIDTH - BK_W;
    localparam int DEPTH = 1 << ROW_W;

    logic [WE_W-1:0]       we_a   [NUM_PORTS];
    logic [ROW_W-1:0]      row_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] din_a  [NUM_PORTS];
    logic [BKI_W-1:0]      bank_a [NUM_PORTS];
    logic [NUM_PORTS-1:0]  gnt    [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rdata  [NUM_BANKS];

    // Low address bits pick the bank so consecutive words spread across banks.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            we_a[p]   = we[p*WE_W +: WE_W];
            din_a[p]  = din[p*DATA_WIDTH +: DATA_WIDTH];
            row_a[p]  = ROW_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> BK_W);
            bank_a[p] = BKI_W'(addr[p*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_WIDTH'(NUM_BANKS - 1));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0]  req;
        logic [WE_W-1:0]       bwe;
        logic [ROW_W-1:0]      brow;
        logic [DATA_WIDTH-1:0] bdin;
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_comb begin
            req = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[p] = rstn & en[p] & (bank_a[p] == BKI_W'(b));
            end
        end

        cnnip_mem_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk  (clk),
            .rstn (rstn),
            .req  (req),
            .gnt  (gnt[b])
        );

        always_comb begin
            bwe  = '0;
            brow = '0;
            bdin = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[b][p]) begin
                    bwe  = we_a[p];
                    brow = row_a[p];
                    bdin = din_a[p];
                end
            end
        end

        // Array stage: write lanes or register the read word (one access per bank per cycle).
        always_ff @(posedge clk) begin
            if (|gnt[b]) begin
                if (|bwe) begin
                    for (int i = 0; i < WE_W; i++) begin
                        if (bwe[i]) mem[brow][i*8 +: 8] <= bdin[i*8 +: 8];
                    end
                end else begin
                    rdata[b] <= mem[brow];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rd_tag_t               tag_p0;
        logic                  vld_p1;
        logic [DATA_WIDTH-1:0] data_p1;

        assign ready[p] = rstn & (~en[p] | gnt[bank_a[p]][p]);

        // Stage p0: tag the accepted read with its bank.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                tag_p0 <= '0;
            end else begin
                tag_p0.vld  <= en[p] & ready[p] & ~(|we_a[p]);
                tag_p0.bank <= TAG_BK_W'(bank_a[p]);
            end
        end

        // Stage p1: pick the bank output; zero when no read is in flight.
        always_comb begin
            vld_p1  = tag_p0.vld;
            data_p1 = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (tag_p0.vld && tag_p0.bank == TAG_BK_W'(b)) data_p1 = rdata[b];
            end
        end

        if (RD_LATENCY == 1) begin : g_l1
            assign valid[p]                          = vld_p1;
            assign dout[p*DATA_WIDTH +: DATA_WIDTH] = data_p1;
        end else begin : g_ln
            logic [RD_LATENCY-2:0] vld_pn;
            logic [DATA_WIDTH-1:0] data_pn [RD_LATENCY-1];

            // Stages p2..pN: delay line out to the requested latency.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    vld_pn <= '0;
                    for (int k = 0; k < RD_LATENCY-1; k++) data_pn[k] <= '0;
                end else begin
                    vld_pn[0]  <= vld_p1;
                    data_pn[0] <= data_p1;
                    for (int k = 1; k < RD_LATENCY-1; k++) begin
                        vld_pn[k]  <= vld_pn[k-1];
                        data_pn[k] <= data_pn[k-1];
                    end
                end
            end

            assign valid[p]                          = vld_pn[RD_LATENCY-2];
            assign dout[p*DATA_WIDTH +: DATA_WIDTH] = data_pn[RD_LATENCY-2];
        end
    end

endmodule

// File: tb/tb_cnnip_mem_banked.sv
// Scoreboard bench for cnnip_mem_banked: directed scenarios plus randomized traffic.
module tb_cnnip_mem_banked;

    localparam int AW = 12, DW = 32, NP = 2, NB = 4, RDL = 2, WEW = DW / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NP-1:0]     en;
    logic [NP*WEW-1:0] we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  din;
    logic [NP-1:0]     ready;
    logic [NP*DW-1:0]  dout;
    logic [NP-1:0]     valid;

    cnnip_mem_banked #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP), .NUM_BANKS(NB), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .we(we), .addr(addr), .din(din),
        .ready(ready), .dout(dout), .valid(valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t          sbq [NP][$];
    logic [DW-1:0] mm [1<<AW];
    int            rr_m [NB];

    bit            r_en   [NP];
    logic [WEW-1:0] r_we  [NP];
    logic [AW-1:0] r_addr [NP];
    logic [DW-1:0] r_din  [NP];
    bit            acc    [NP];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pops the oldest expected read of that port.
    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (valid[p] !== 1'b0) begin
                if (sbq[p].size() == 0) begin
                    chk($sformatf("unexpected_valid_p%0d", p), 32'(valid[p]), 32'd0);
                end else begin
                    e = sbq[p].pop_front();
                    chk($sformatf("rdata_p%0d", p), dout[p*DW +: DW], e.d);
                    chk($sformatf("rd_latency_p%0d", p), cyc, e.c);
                end
            end
        end
    end

    // One bus cycle: drive the held requests, predict grants, check ready, update the model.
    task automatic cycle();
        bit g [NP];
        bit f;
        int start, p;
        @(posedge clk);
        #1;
        for (int q = 0; q < NP; q++) begin
            en[q]             = r_en[q];
            we[q*WEW +: WEW]  = r_we[q];
            addr[q*AW +: AW]  = r_addr[q];
            din[q*DW +: DW]   = r_din[q];
            g[q]              = 1'b0;
        end
        #2;
        for (int b = 0; b < NB; b++) begin
            f     = 1'b0;
            start = rr_m[b];
            for (int k = 0; k < NP; k++) begin
                p = (start + k) % NP;
                if (!f && r_en[p] && (int'(r_addr[p]) % NB) == b) begin
                    f       = 1'b1;
                    g[p]    = 1'b1;
                    rr_m[b] = (p + 1) % NP;
                end
            end
        end
        for (int q = 0; q < NP; q++) begin
            chk($sformatf("ready_p%0d", q), 32'(ready[q]), 32'(!r_en[q] || g[q]));
            acc[q] = r_en[q] && g[q];
            if (acc[q]) begin
                if (r_we[q] != 0) begin
                    for (int i = 0; i < WEW; i++)
                        if (r_we[q][i]) mm[r_addr[q]][i*8 +: 8] = r_din[q][i*8 +: 8];
                end else begin
                    sbq[q].push_back('{mm[r_addr[q]], cyc + RDL});
                end
            end
        end
    endtask

    task automatic req(input int p, input logic [WEW-1:0] w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        r_en[p] = 1'b1; r_we[p] = w; r_addr[p] = a; r_din[p] = d;
    endtask

    function automatic bit any_en();
        bit r = 1'b0;
        for (int p = 0; p < NP; p++) r |= r_en[p];
        return r;
    endfunction

    task automatic go();
        int n = 0;
        while (any_en() && n < 16) begin
            cycle();
            for (int p = 0; p < NP; p++) if (acc[p]) r_en[p] = 1'b0;
            n++;
        end
        if (any_en()) begin
            chk("accept_timeout", 32'd1, 32'd0);
            for (int p = 0; p < NP; p++) r_en[p] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int p = 0; p < NP; p++) r_en[p] = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; en = '0; we = '0; addr = '0; din = '0;
        for (int p = 0; p < NP; p++) begin
            r_en[p] = 1'b0; r_we[p] = '0; r_addr[p] = '0; r_din[p] = '0; acc[p] = 1'b0;
        end
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        #12;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_dout", dout[DW-1:0] | dout[2*DW-1:DW], 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single-port write then read
        req(0, 4'hF, 12'h005, 32'hDEADBEEF); go();
        req(0, 4'h0, 12'h005, 32'h0);        go();
        idle(3);

        // Byte enables: lanes 0 and 2 replaced
        req(0, 4'hF, 12'h007, 32'h11223344); go();
        req(0, 4'h5, 12'h007, 32'hAABBCCDD); go();
        req(0, 4'h0, 12'h007, 32'h0);        go();
        idle(3);

        // Bank 1 conflict after priming both words
        req(0, 4'hF, 12'h001, 32'hA5A50001); go();
        req(1, 4'hF, 12'h005, 32'h5A5A0005); go();
        for (int i = 0; i < 4; i++) begin
            req(0, 4'h0, 12'h001, 32'h0);
            req(1, 4'h0, 12'h005, 32'h0);
            cycle();
            chk("conflict_ready0", 32'(ready[0]), 32'(i % 2 == 0));
            chk("conflict_ready1", 32'(ready[1]), 32'(i % 2 == 1));
        end
        idle(4);

        // Different banks in the same cycle
        req(0, 4'hF, 12'h000, $urandom); req(1, 4'hF, 12'h003, $urandom); go();
        req(0, 4'h0, 12'h000, 32'h0);    req(1, 4'h0, 12'h003, 32'h0);
        cycle();
        chk("noconflict_ready", 32'(ready), 32'h3);
        idle(4);

        // Read-after-write across ports
        req(1, 4'hF, 12'h010, 32'h00000055); cycle();
        chk("raw_write_ready", 32'(ready[1]), 32'd1);
        r_en[1] = 1'b0;
        req(0, 4'h0, 12'h010, 32'h0); cycle();
        chk("raw_read_ready", 32'(ready[0]), 32'd1);
        idle(4);

        // Reset while a read is in flight
        req(0, 4'h0, 12'h005, 32'h0); cycle();
        r_en[0] = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        for (int p = 0; p < NP; p++) sbq[p].delete();
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        en = 2'b01; we = '0; addr = '0;
        #2;
        chk("midreset_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("midreset_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        en = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postreset_valid", 32'(valid), 32'd0);
            chk("postreset_dout", dout[DW-1:0] | dout[2*DW-1:DW], 32'd0);
        end
        req(0, 4'h0, 12'h005, 32'h0); go();
        idle(4);

        // Randomized traffic over a small, fully initialised address pool
        for (int a = 0; a < 16; a++) begin
            req(0, 4'hF, 12'(a), $urandom); go();
        end
        for (int t = 0; t < 800; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (!r_en[p] && $urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 2) == 0)
                        req(p, 4'($urandom_range(1, 15)), 12'($urandom_range(0, 15)), $urandom);
                    else
                        req(p, 4'h0, 12'($urandom_range(0, 15)), 32'h0);
                end
            end
            cycle();
            for (int p = 0; p < NP; p++) if (acc[p]) r_en[p] = 1'b0;
        end
        idle(RDL + 3);
        for (int p = 0; p < NP; p++)
            chk($sformatf("scoreboard_empty_p%0d", p), sbq[p].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
